// File: rtl/cod_debug_pkg.sv
// Shared debug-side definitions: scanner FSM states and check-data sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cod_debug_pkg;

  localparam int CHECK_NUM_ENTRIES = 25;
  localparam int CHECK_ADDR_W      = 5;
  localparam int CHECK_DATA_W      = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2
  } scan_state_e;

endpackage

// File: rtl/snapshot_buf.sv
// Snapshot register array: one synchronous write port, one combinational read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the array is not reset.
// Ports: clk, we/wa/wd (write), ra -> rd (read).
module snapshot_buf #(
  parameter int NUM_ENTRIES = 25,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] mem [NUM_ENTRIES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd = mem[ra];

endmodule

// File: rtl/check_data_scanner.sv
// Sweeps check_addr over all debug indices with the CPU held, then streams (addr, data) words out.
// Latency: SCAN takes NUM_ENTRIES cycles after start; first word in the following cycle; done one cycle after last accept.
// Backpressure: out_valid holds with stable addr/data until out_ready; start outside IDLE is dropped.
// Ports: clk, rstn, start, busy, cpu_hold, check_addr/check_data (mux side), out_valid/out_ready/out_addr/out_data (host side), done.
module check_data_scanner
  import cod_debug_pkg::*;
#(
  parameter int NUM_ENTRIES = CHECK_NUM_ENTRIES,
  parameter int ADDR_W      = CHECK_ADDR_W,
  parameter int DATA_W      = CHECK_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              busy,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] check_addr,
  input  logic [DATA_W-1:0] check_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              done
);

  // Terminal compare is against the last implemented entry, so idx never wraps.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ENTRIES - 1);

  scan_state_e       state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic              done_nxt;
  logic [DATA_W-1:0] buf_rd;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      idx   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        idx_nxt = '0;
        if (start) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (idx == LAST_IDX) begin
          state_nxt = SEND;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + ADDR_W'(1);
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx == LAST_IDX) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // All outputs decode registered state; check_data only reaches out_data
  // through the snapshot array, never combinationally.
  assign busy       = (state != IDLE);
  assign cpu_hold   = (state == SCAN);
  assign check_addr = (state == SCAN) ? idx : '0;
  assign out_valid  = (state == SEND);
  assign out_addr   = (state == SEND) ? idx : '0;
  assign out_data   = (state == SEND) ? buf_rd : '0;

  // check_data for the driven index is captured on the edge that ends that SCAN cycle.
  snapshot_buf #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W)
  ) u_snapshot_buf (
    .clk (clk),
    .we  (state == SCAN),
    .wa  (idx),
    .wd  (check_data),
    .ra  (idx),
    .rd  (buf_rd)
  );

endmodule

// File: tb/tb_check_data_scanner.sv
module tb_check_data_scanner;

  localparam int N = 25;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        busy, cpu_hold, out_valid, done;
  logic [4:0]  check_addr, out_addr;
  logic [31:0] check_data, out_data;
  logic        out_ready;

  logic        start1, busy1, cpu_hold1, out_valid1, done1, out_ready1;
  logic [4:0]  check_addr1, out_addr1;
  logic [31:0] check_data1, out_data1;

  logic [31:0] cyc_cnt = 32'h1234_0000;
  bit          mux_cnt_mode = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 32'd1;

  // Check-data mux models: fixed pattern or a free-running counter.
  assign check_data  = mux_cnt_mode ? cyc_cnt : (32'hA500_0000 | 32'(check_addr));
  assign check_data1 = 32'hA500_0000 | 32'(check_addr1);

  check_data_scanner #(.NUM_ENTRIES(N), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .cpu_hold(cpu_hold),
    .check_addr(check_addr), .check_data(check_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data), .done(done)
  );

  check_data_scanner #(.NUM_ENTRIES(1), .ADDR_W(5), .DATA_W(32)) dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .busy(busy1), .cpu_hold(cpu_hold1),
    .check_addr(check_addr1), .check_data(check_data1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_addr(out_addr1), .out_data(out_data1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One full scan+send transaction checked cycle by cycle.
  // rdy_mode: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
  task automatic run_scan(input int rdy_mode, input bit cnt_mode, input bit inj_start);
    logic [31:0] exp_q [N];
    logic [31:0] c0;
    int          j, w, sendc;
    bit          rdy, injected, finished;
    mux_cnt_mode = cnt_mode;
    @(negedge clk);                       // cycle 0
    c0 = cyc_cnt;
    for (int k = 0; k < N; k++)
      exp_q[k] = cnt_mode ? (c0 + 32'(k) + 32'd1) : (32'hA500_0000 + 32'(k));
    start = 1'b1;
    j = 1; w = 0; sendc = 0; injected = 1'b0; finished = 1'b0;
    while (j < 400 && !finished) begin
      @(negedge clk);                     // cycle j
      start = 1'b0;
      if (j <= N) begin
        chk("scan_hold", 32'(cpu_hold), 32'd1);
        chk("scan_busy", 32'(busy), 32'd1);
        chk("scan_addr", 32'(check_addr), 32'(j - 1));
        chk("scan_valid", 32'(out_valid), 32'd0);
        chk("scan_done", 32'(done), 32'd0);
        if (inj_start && j == 3) start = 1'b1;
      end else if (w < N) begin
        chk("send_valid", 32'(out_valid), 32'd1);
        chk("send_hold", 32'(cpu_hold), 32'd0);
        chk("send_addr", 32'(out_addr), 32'(w));
        chk("send_data", out_data, exp_q[w]);
        chk("send_done", 32'(done), 32'd0);
        case (rdy_mode)
          0:       rdy = 1'b1;
          1:       rdy = (sendc % 4 == 0) || (sendc % 4 == 3);
          default: rdy = 1'($urandom_range(1, 0));
        endcase
        out_ready = rdy;
        if (inj_start && w == 10 && !injected) begin
          start = 1'b1;
          injected = 1'b1;
        end
        sendc++;
        if (rdy) w++;
      end else begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_valid", 32'(out_valid), 32'd0);
        chk("done_data", out_data, 32'd0);
        if (rdy_mode == 0) chk("done_cycle", 32'(j), 32'(2 * N + 1));
        finished = 1'b1;
      end
      j++;
    end
    if (!finished) chk("timeout", 32'd0, 32'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; out_ready = 1'b0;
    start1 = 1'b0; out_ready1 = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_caddr", 32'(check_addr), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_oaddr", 32'(out_addr), 32'd0);
    chk("rst_odata", out_data, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    run_scan(0, 1'b0, 1'b0);   // basic sweep
    run_scan(1, 1'b0, 1'b0);   // backpressure 1,0,0,1
    run_scan(0, 1'b0, 1'b1);   // ignored starts
    run_scan(2, 1'b1, 1'b0);   // counter source, random ready
    run_scan(1, 1'b1, 1'b1);

    // Reset mid-scan at SCAN cycle 12.
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_addr", 32'(check_addr), 32'd11);
    rstn = 1'b0;
    #1;
    chk("mid_rst_hold", 32'(cpu_hold), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_caddr", 32'(check_addr), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    chk("mid_rst_done", 32'(done), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    run_scan(0, 1'b0, 1'b0);

    // Single-entry instance.
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);            // cycle 1
    start1 = 1'b0;
    chk("n1_hold", 32'(cpu_hold1), 32'd1);
    chk("n1_caddr", 32'(check_addr1), 32'd0);
    chk("n1_valid0", 32'(out_valid1), 32'd0);
    out_ready1 = 1'b1;
    @(negedge clk);            // cycle 2
    chk("n1_valid", 32'(out_valid1), 32'd1);
    chk("n1_hold2", 32'(cpu_hold1), 32'd0);
    chk("n1_oaddr", 32'(out_addr1), 32'd0);
    chk("n1_odata", out_data1, 32'hA500_0000);
    chk("n1_done0", 32'(done1), 32'd0);
    @(negedge clk);            // cycle 3
    chk("n1_done", 32'(done1), 32'd1);
    chk("n1_busy", 32'(busy1), 32'd0);
    @(negedge clk);
    chk("n1_done_after", 32'(done1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
